// File: rtl/lvds_rx_align_if.sv
// LVDS RX word-alignment control bundle.
// master drives the controls and data; slave is the alignment controller.
interface lvds_rx_align_if #(
  parameter int DATA_W = 10,
  parameter int SC_W   = $clog2(DATA_W + 1)
);
  logic              init_done;
  logic              rx_dpa_locked;
  logic              align_start;
  logic [DATA_W-1:0] rx_data;
  logic              rx_bitslip;
  logic              aligned;
  logic              align_fail;
  logic              relink_req;
  logic [SC_W-1:0]   slip_count;

  modport master (
    output init_done, rx_dpa_locked, align_start, rx_data,
    input  rx_bitslip, aligned, align_fail, relink_req, slip_count
  );

  modport slave (
    input  init_done, rx_dpa_locked, align_start, rx_data,
    output rx_bitslip, aligned, align_fail, relink_req, slip_count
  );
endinterface

// File: rtl/lvds_rx_align_ctrl.sv
// LVDS RX word aligner: slips the deserializer until
// TRAIN_PATTERN is seen MATCH_COUNT times in a row.
module lvds_rx_align_ctrl #(
  parameter int                DATA_W        = 10,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 10'h3F0,
  parameter int                SLIP_SETTLE   = 4,
  parameter int                MATCH_COUNT   = 16,
  parameter int                SC_W          = $clog2(DATA_W + 1)
) (
  input logic            clk,
  input logic            rst,
  lvds_rx_align_if.slave bus
);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = $clog2(SLIP_SETTLE + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOCK, CHECK, SLIP, SETTLE, ALIGNED, FAIL
  } state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   match_q, match_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [SC_W-1:0] slip_q, slip_d;
  logic            relink_d;
  logic            bitslip_q, aligned_q, fail_q, relink_q;
  logic            hit, searching;

  assign hit       = bus.rx_data == TRAIN_PATTERN;
  assign searching = state_q == CHECK || state_q == SLIP ||
                     state_q == SETTLE;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    settle_d = settle_q;
    slip_d   = slip_q;
    relink_d = 1'b0;
    if (!bus.init_done) begin
      state_d  = IDLE;
      match_d  = '0;
      settle_d = '0;
      slip_d   = '0;
    end else if (!bus.rx_dpa_locked && state_q == ALIGNED) begin
      state_d  = IDLE;
      relink_d = 1'b1;
    end else if (!bus.rx_dpa_locked && searching) begin
      state_d  = WAIT_LOCK;
      match_d  = '0;
      settle_d = '0;
      slip_d   = '0;
    end else if (bus.align_start &&
                 (searching || state_q == ALIGNED ||
                  state_q == FAIL)) begin
      state_d  = bus.rx_dpa_locked ? CHECK : WAIT_LOCK;
      match_d  = '0;
      settle_d = '0;
      slip_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.align_start) begin
            state_d = bus.rx_dpa_locked ? CHECK : WAIT_LOCK;
            match_d = '0;
            slip_d  = '0;
          end
        end
        WAIT_LOCK: begin
          if (bus.rx_dpa_locked) begin
            state_d = CHECK;
            match_d = '0;
          end
        end
        CHECK: begin
          if (hit) begin
            match_d = match_q + MW'(1);
            if (match_q == MW'(MATCH_COUNT - 1))
              state_d = ALIGNED;
          end else begin
            match_d = '0;
            state_d = (slip_q == SC_W'(DATA_W - 1)) ? FAIL : SLIP;
          end
        end
        SLIP: begin
          slip_d   = slip_q + SC_W'(1);
          settle_d = SW'(SLIP_SETTLE);
          state_d  = SETTLE;
        end
        SETTLE: begin
          // rx_data is not trusted until the slip has propagated
          if (settle_q <= SW'(1)) begin
            settle_d = '0;
            match_d  = '0;
            state_d  = CHECK;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        ALIGNED: state_d = ALIGNED;
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      match_q   <= '0;
      settle_q  <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      fail_q    <= 1'b0;
      relink_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      settle_q  <= settle_d;
      slip_q    <= slip_d;
      bitslip_q <= state_d == SLIP;
      aligned_q <= state_d == ALIGNED;
      fail_q    <= state_d == FAIL;
      relink_q  <= relink_d;
    end
  end

  assign bus.rx_bitslip = bitslip_q;
  assign bus.aligned    = aligned_q;
  assign bus.align_fail = fail_q;
  assign bus.relink_req = relink_q;
  assign bus.slip_count = slip_q;
endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Bench for lvds_rx_align_ctrl: a rotating deserializer model
// plus timing expectations derived from the alignment rules.
module tb_lvds_rx_align_ctrl;
  localparam int         DW    = 10;
  localparam int         SS    = 4;
  localparam int         MC    = 16;
  localparam logic [9:0] TRAIN = 10'h3F0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lvds_rx_align_if #(.DATA_W(DW)) bus ();

  lvds_rx_align_ctrl #(
    .DATA_W(DW), .TRAIN_PATTERN(TRAIN),
    .SLIP_SETTLE(SS), .MATCH_COUNT(MC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned slips_total = 0;
  int unsigned relink_cycles = 0;
  int unsigned wide_pulses = 0;
  int unsigned pulse_q[$];
  logic        bs_prev = 1'b0;

  logic        data_fixed = 1'b1;
  logic [9:0]  fixed_word = '0;
  int unsigned rot_base = 0;

  function automatic logic [9:0] rotl(input logic [9:0] w,
                                      input int n);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  // deserializer: word is TRAIN rotated by the slips still owed
  function automatic logic [9:0] word_at(input int unsigned base,
                                         input int unsigned n);
    int off;
    off = (int'(base) - int'(n)) % DW;
    if (off < 0) off += DW;
    return rotl(TRAIN, off);
  endfunction

  always_comb
    bus.rx_data = data_fixed ? fixed_word
                             : word_at(rot_base, slips_total);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_bitslip) slips_total <= slips_total + 1;
  end

  always @(negedge clk) begin
    if (bus.rx_bitslip) begin
      if (bs_prev) wide_pulses <= wide_pulses + 1;
      else pulse_q.push_back(cyc);
    end
    bs_prev <= bus.rx_bitslip;
    if (bus.relink_req) relink_cycles <= relink_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int unsigned e);
    bus.align_start = 1'b1;
    tick();
    e = cyc;
    bus.align_start = 1'b0;
  endtask

  task automatic to_idle(input logic lock);
    bus.init_done = 1'b0;
    tick();
    bus.init_done = 1'b1;
    bus.rx_dpa_locked = lock;
    tick();
  endtask

  task automatic wait_high(input bit fail_sel,
                           output int unsigned t);
    t = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fail_sel ? bus.align_fail : bus.aligned) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic search_trial(input int k, input bit lock_first,
                              input int w);
    int unsigned e, c, t;
    to_idle(lock_first);
    data_fixed = 1'b0;
    rot_base = k + slips_total;
    pulse_q.delete();
    pulse_start(e);
    c = e;
    if (!lock_first) begin
      tick(w);
      bus.rx_dpa_locked = 1'b1;
      tick();
      c = cyc;
    end
    wait_high(1'b0, t);
    check("align_time", t, c + (SS + 2) * k + MC);
    check("align_slips", bus.slip_count, k);
    check("align_nofail", bus.align_fail, 0);
    check("align_npulse", pulse_q.size(), k);
    for (int i = 0; i < pulse_q.size() && i < k; i++)
      check("slip_time", pulse_q[i], c + 1 + (SS + 2) * i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e, c, t, r0, k;
    logic        bad;
    bus.init_done     = 1'b0;
    bus.rx_dpa_locked = 1'b0;
    bus.align_start   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {bus.slip_count, bus.relink_req,
          bus.align_fail, bus.aligned, bus.rx_bitslip}, 0);
    rst = 1'b1;
    bus.init_done = 1'b1;
    bus.rx_dpa_locked = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.rx_bitslip || bus.aligned || bus.align_fail ||
          bus.relink_req || bus.slip_count != 0) bad = 1'b1;
    end
    check("idle_outs", bad, 0);
    check("idle_pulses", pulse_q.size(), 0);

    search_trial(0, 1'b1, 0);
    search_trial(3, 1'b1, 0);
    for (int n = 0; n < 6; n++)
      search_trial($urandom_range(DW - 1), 1'($urandom_range(1)),
                   $urandom_range(5));

    to_idle(1'b1);
    data_fixed = 1'b1;
    do fixed_word = 10'($urandom); while (fixed_word == TRAIN);
    pulse_q.delete();
    pulse_start(c);
    wait_high(1'b1, t);
    check("fail_time", t, c + (DW - 1) * (SS + 2) + 1);
    check("fail_slips", bus.slip_count, DW - 1);
    check("fail_aligned", bus.aligned, 0);
    check("fail_npulse", pulse_q.size(), DW - 1);
    tick(5);
    check("fail_hold", {bus.align_fail, bus.slip_count},
          {1'b1, 4'(DW - 1)});
    pulse_start(e);
    check("restart_clr", {bus.align_fail, bus.slip_count}, 0);
    tick();
    check("restart_slip", bus.rx_bitslip, 1);

    search_trial($urandom_range(DW - 1), 1'b1, 0);
    r0 = relink_cycles;
    bus.rx_dpa_locked = 1'b0;
    tick();
    check("relink_pulse", bus.relink_req, 1);
    check("relink_aligned", bus.aligned, 0);
    tick(3);
    check("relink_width", relink_cycles - r0, 1);
    bus.rx_dpa_locked = 1'b1;
    tick(20);
    check("relink_idle", bus.aligned, 0);

    search_trial($urandom_range(DW - 1), 1'b1, 0);
    r0 = relink_cycles;
    bus.init_done = 1'b0;
    tick();
    check("init_aligned", bus.aligned, 0);
    bus.init_done = 1'b1;
    tick(20);
    check("init_norelink", relink_cycles - r0, 0);
    check("init_idle", bus.aligned, 0);

    k = $urandom_range(DW - 1, 2);
    to_idle(1'b1);
    data_fixed = 1'b0;
    rot_base = k + slips_total;
    pulse_start(c);
    tick();
    check("mid_slip1", bus.rx_bitslip, 1);
    tick();
    bus.rx_dpa_locked = 1'b0;
    tick();
    check("mid_drop_slips", bus.slip_count, 0);
    check("mid_drop_bs", bus.rx_bitslip, 0);
    tick($urandom_range(4, 1));
    bus.rx_dpa_locked = 1'b1;
    tick();
    c = cyc;
    wait_high(1'b0, t);
    check("mid_align_time", t, c + (SS + 2) * (k - 1) + MC);
    check("mid_align_slips", bus.slip_count, k - 1);

    to_idle(1'b1);
    rot_base = $urandom_range(DW - 1, 1) + slips_total;
    pulse_start(c);
    tick();
    check("rst_slip_pre", bus.rx_bitslip, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_trunc", {bus.slip_count, bus.relink_req,
          bus.align_fail, bus.aligned, bus.rx_bitslip}, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("pulse_width", wide_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/lvds_rx_align_ctrl.md
Name: lvds_rx_align_ctrl

Overview:
- Word-alignment controller for the LVDS receiver channel, downstream of the LVDS init sequencer.
- Once init is complete and DPA is locked, compares deserialized words against a training pattern and pulses the bitslip input until the pattern is stable.
- Reports aligned/fail status and requests re-initialization when DPA lock is lost after alignment.

Parameters:
- DATA_W, 10, deserialization factor; width of rx_data.
- TRAIN_PATTERN, 10'h3F0, expected word when aligned; DATA_W bits.
- SLIP_SETTLE, 4, cycles to wait after each bitslip pulse before re-checking; must be >=1.
- MATCH_COUNT, 16, consecutive matching words required to declare alignment; must be >=1.
- SC_W, $clog2(DATA_W+1), width of slip_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; all state is cleared while low.
- init_done  in  1  high once the LVDS init sequencer has released all resets.
- rx_dpa_locked  in  1  DPA lock from the LVDS RX core.
- align_start  in  1  one-cycle request to (re)start alignment.
- rx_data  in  DATA_W  parallel word from the deserializer, valid every cycle.
- rx_bitslip  out  1  one-cycle registered pulse to the core's data-align input.
- aligned  out  1  high while in ALIGNED.
- align_fail  out  1  high while in FAIL.
- relink_req  out  1  one-cycle pulse when DPA lock is lost while ALIGNED.
- slip_count  out  SC_W  bitslips issued in the current attempt.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; match_cnt, settle_cnt and slip_count are 0.
- All outputs are registered.
- States: IDLE, WAIT_LOCK, CHECK, SLIP, SETTLE, ALIGNED, FAIL.
- IDLE: on align_start with init_done high, clear slip_count and go to CHECK if rx_dpa_locked is high, else go to WAIT_LOCK. align_start while init_done is low is ignored.
- WAIT_LOCK: go to CHECK with match_cnt=0 when rx_dpa_locked is high.
- CHECK: compare rx_data to TRAIN_PATTERN every cycle.
  - Match: match_cnt increments. When the MATCH_COUNT-th consecutive match is sampled, go to ALIGNED. aligned=1 from that edge.
  - Mismatch: match_cnt clears. If slip_count==DATA_W-1, go to FAIL; otherwise go to SLIP.
- SLIP: one cycle. rx_bitslip=1 for exactly this cycle, slip_count increments, settle_cnt loads SLIP_SETTLE, go to SETTLE.
- SETTLE: decrement settle_cnt; when it reaches 0, go to CHECK with match_cnt=0. rx_data is ignored throughout SETTLE.
- Bitslip pulses are always separated by at least SLIP_SETTLE+2 cycles: SLIP, SETTLE x SLIP_SETTLE, then at least one CHECK cycle.
- ALIGNED: aligned is held high. A mismatch in ALIGNED does not drop alignment; monitoring is by DPA lock only.
- FAIL: align_fail is held high. slip_count holds DATA_W-1.
- Priority, highest first, evaluated every cycle:
  1. init_done low: go to IDLE and clear all counters and outputs; no relink_req.
  2. rx_dpa_locked low:
     - from ALIGNED: pulse relink_req for one cycle, clear aligned, go to IDLE.
     - from CHECK/SLIP/SETTLE: go to WAIT_LOCK, clear match_cnt and slip_count.
     - an in-flight rx_bitslip pulse is never extended.
  3. align_start in ALIGNED, FAIL, CHECK, SLIP or SETTLE: restart. Clear aligned, align_fail, match_cnt and slip_count; go to CHECK or WAIT_LOCK per rx_dpa_locked.
  4. Normal transitions as listed above.
- slip_count never exceeds DATA_W-1; no wrap-around.
- Reset asserted mid-operation takes effect immediately (asynchronous). Any rx_bitslip pulse is truncated.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with align_start=0 -> all outputs 0 and no rx_bitslip for 50 cycles.
- Already aligned: init_done=1, rx_dpa_locked=1, rx_data=10'h3F0 constant, pulse align_start -> aligned rises 16 cycles after CHECK entry; slip_count=0; zero bitslip pulses.
- Slip search: bench rotates rx_data by one bit per rx_bitslip, starting 3 rotations off -> exactly 3 rx_bitslip pulses, each 1 cycle wide and spaced 6 cycles apart; aligned=1 with slip_count=3.
- Fail: rx_data held at 10'h000 -> 9 bitslip pulses, then align_fail=1 with slip_count=9 and aligned=0; a later align_start clears align_fail and restarts the search.
- Lock loss: while aligned, drop rx_dpa_locked -> relink_req high for exactly 1 cycle, aligned=0 next edge, state IDLE. Repeat with init_done dropped instead -> no relink_req.
- Mid-search disturbance: drop rx_dpa_locked during SETTLE -> WAIT_LOCK with slip_count=0; restore lock -> search resumes from CHECK. Assert rst low mid-SLIP -> rx_bitslip=0 immediately.
